// File: rtl/rc_pattern_checker.sv
// Monitors a ring counter output. Each qualified sample must be a one-step rotation of the
// previous one. Reports period length and completed periods, and flags and counts rotation faults.
module rc_pattern_checker #(
  parameter int unsigned WIDTH = 4,
  parameter bit          DIR   = 1'b0,
  parameter int unsigned CNTW  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       q_in,
  input  logic                   valid,
  input  logic                   clear,
  output logic                   locked,
  output logic                   per_done,
  output logic [$clog2(WIDTH):0] per_len,
  output logic [CNTW-1:0]        per_cnt,
  output logic                   err,
  output logic [CNTW-1:0]        err_cnt
);

  localparam int unsigned LenW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StFault
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  seed_q, seed_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [LenW-1:0]   step_q, step_d;
  logic [LenW-1:0]   per_len_q, per_len_d;
  logic [CNTW-1:0]   per_cnt_q, per_cnt_d;
  logic [CNTW-1:0]   err_cnt_q, err_cnt_d;
  logic              per_done_q, per_done_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  expected;

  // Single-bit rings are trivially rotation-invariant.
  if (WIDTH == 1) begin : g_rot_w1
    assign expected = prev_q;
  end else if (DIR) begin : g_rot_right
    assign expected = {prev_q[0], prev_q[WIDTH-1:1]};
  end else begin : g_rot_left
    assign expected = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
  end

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    prev_d     = prev_q;
    step_d     = step_q;
    per_len_d  = per_len_q;
    per_cnt_d  = per_cnt_q;
    err_cnt_d  = err_cnt_q;
    per_done_d = 1'b0;
    err_d      = 1'b0;

    if (clear) begin
      state_d   = StIdle;
      step_d    = '0;
      per_len_d = '0;
      per_cnt_d = '0;
      err_cnt_d = '0;
    end else if (valid) begin
      unique case (state_q)
        StTrack: begin
          if (q_in == expected) begin
            prev_d = q_in;
            if (q_in == seed_q) begin
              per_done_d = 1'b1;
              per_len_d  = step_q + 1'b1;
              step_d     = '0;
              if (per_cnt_q != {CNTW{1'b1}}) begin
                per_cnt_d = per_cnt_q + 1'b1;
              end
            end else begin
              step_d = step_q + 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = StFault;
            if (err_cnt_q != {CNTW{1'b1}}) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
        end
        // Idle and fault both take the sample as a fresh seed.
        StIdle, StFault: begin
          seed_d  = q_in;
          prev_d  = q_in;
          step_d  = '0;
          state_d = StTrack;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      seed_q     <= '0;
      prev_q     <= '0;
      step_q     <= '0;
      per_len_q  <= '0;
      per_cnt_q  <= '0;
      err_cnt_q  <= '0;
      per_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      per_len_q  <= per_len_d;
      per_cnt_q  <= per_cnt_d;
      err_cnt_q  <= err_cnt_d;
      per_done_q <= per_done_d;
      err_q      <= err_d;
    end
  end

  assign locked   = (state_q == StTrack);
  assign per_done = per_done_q;
  assign per_len  = per_len_q;
  assign per_cnt  = per_cnt_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_rc_pattern_checker.sv
// Scoreboard bench: two checkers (left/CNTW=8 and right/CNTW=2) watch the same stimulus and are
// compared against a per-sample behavioural model.
module tb_rc_pattern_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       valid;
  logic [3:0] q_in;

  logic       locked_a, per_done_a, err_a;
  logic [2:0] per_len_a;
  logic [7:0] per_cnt_a, err_cnt_a;
  logic       locked_b, per_done_b, err_b;
  logic [2:0] per_len_b;
  logic [1:0] per_cnt_b, err_cnt_b;

  rc_pattern_checker #(.WIDTH(4), .DIR(1'b0), .CNTW(8)) dut_a (
    .clk(clk), .rst(rst), .q_in(q_in), .valid(valid), .clear(clear),
    .locked(locked_a), .per_done(per_done_a), .per_len(per_len_a),
    .per_cnt(per_cnt_a), .err(err_a), .err_cnt(err_cnt_a)
  );

  rc_pattern_checker #(.WIDTH(4), .DIR(1'b1), .CNTW(2)) dut_b (
    .clk(clk), .rst(rst), .q_in(q_in), .valid(valid), .clear(clear),
    .locked(locked_b), .per_done(per_done_b), .per_len(per_len_b),
    .per_cnt(per_cnt_b), .err(err_b), .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit tracking;
    int seed, prev, step, per_len, per_cnt, err_cnt;
    bit per_done, err;
  } model_t;

  typedef struct {
    int unsigned due;
    int locked, per_done, err, per_len, per_cnt, err_cnt;
  } exp_t;

  model_t ma, mb;
  exp_t   qa[$];
  exp_t   qb[$];
  int     n_cmp = 0;
  int     n_fail = 0;

  function automatic int rot(input int p, input bit right);
    if (right) return p / 2 + (p % 2) * 8;
    return (p * 2) % 16 + p / 8;
  endfunction

  function automatic model_t model_step(input model_t m, input bit clr, input bit vld,
                                        input int q, input bit right, input int cmax);
    m.per_done = 0;
    m.err = 0;
    if (clr) begin
      m.tracking = 0;
      m.step = 0;
      m.per_len = 0;
      m.per_cnt = 0;
      m.err_cnt = 0;
    end else if (vld) begin
      if (!m.tracking) begin
        m.seed = q;
        m.prev = q;
        m.step = 0;
        m.tracking = 1;
      end else if (q == rot(m.prev, right)) begin
        m.prev = q;
        if (q == m.seed) begin
          m.per_done = 1;
          m.per_len = m.step + 1;
          m.step = 0;
          if (m.per_cnt < cmax) m.per_cnt++;
        end else begin
          m.step++;
        end
      end else begin
        m.err = 1;
        if (m.err_cnt < cmax) m.err_cnt++;
        m.tracking = 0;
      end
    end
    return m;
  endfunction

  function automatic exp_t to_exp(input model_t m, input int unsigned due);
    exp_t e;
    e.due = due;
    e.locked = int'(m.tracking);
    e.per_done = int'(m.per_done);
    e.err = int'(m.err);
    e.per_len = m.per_len;
    e.per_cnt = m.per_cnt;
    e.err_cnt = m.err_cnt;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every expectation whose sampling edge has passed.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (qa.size() > 0 && qa[0].due <= cyc) begin
        e = qa.pop_front();
        check("a.locked", int'(locked_a), e.locked);
        check("a.per_done", int'(per_done_a), e.per_done);
        check("a.err", int'(err_a), e.err);
        check("a.per_len", int'(per_len_a), e.per_len);
        check("a.per_cnt", int'(per_cnt_a), e.per_cnt);
        check("a.err_cnt", int'(err_cnt_a), e.err_cnt);
      end
      while (qb.size() > 0 && qb[0].due <= cyc) begin
        e = qb.pop_front();
        check("b.locked", int'(locked_b), e.locked);
        check("b.per_done", int'(per_done_b), e.per_done);
        check("b.err", int'(err_b), e.err);
        check("b.per_len", int'(per_len_b), e.per_len);
        check("b.per_cnt", int'(per_cnt_b), e.per_cnt);
        check("b.err_cnt", int'(err_cnt_b), e.err_cnt);
      end
    end
  end

  task automatic apply(input bit c, input bit v, input int q);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear = c;
    valid = v;
    q_in = 4'(q);
    ma = model_step(ma, c, v, q, 1'b0, 255);
    mb = model_step(mb, c, v, q, 1'b1, 3);
    qa.push_back(to_exp(ma, cyc + 1));
    qb.push_back(to_exp(mb, cyc + 1));
  endtask

  // Asserted between edges so the async path is observable before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("a.async_rst_locked", int'(locked_a), 0);
    check("a.async_rst_per_len", int'(per_len_a), 0);
    check("b.async_rst_err_cnt", int'(err_cnt_b), 0);
    ma = model_t'{default: 0};
    mb = model_t'{default: 0};
    qa.push_back(to_exp(ma, cyc + 1));
    qb.push_back(to_exp(mb, cyc + 1));
  endtask

  task automatic seq(input int n, input int vals[]);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b1, vals[i]);
  endtask

  initial begin
    int cur;
    bit dsel;
    int r;
    rst = 1'b1;
    clear = 1'b0;
    valid = 1'b0;
    q_in = 4'h0;
    ma = model_t'{default: 0};
    mb = model_t'{default: 0};
    repeat (2) @(posedge clk);
    #2;
    check("reset_locked", int'(locked_a), 0);
    check("reset_per_cnt", int'(per_cnt_a), 0);
    check("reset_err", int'(err_b), 0);

    seq(5, '{4'b1010, 4'b0101, 4'b1010, 4'b0101, 4'b1010});
    apply(1'b1, 1'b1, 4'b0101);
    seq(5, '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001});
    apply(1'b1, 1'b0, 0);
    seq(5, '{4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1000});
    apply(1'b1, 1'b0, 0);
    seq(4, '{4'b0011, 4'b0011, 4'b0011, 4'b0011});
    apply(1'b1, 1'b0, 0);
    // Valid gaps with a rotating input: the held-off samples must be ignored.
    cur = 1;
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b1, cur);
      apply(1'b0, 1'b0, 4'hF);
      cur = rot(cur, 1'b0);
    end
    seq(3, '{4'b0000, 4'b0000, 4'b1111});
    seq(3, '{4'b1111, 4'b1111, 4'b1111});
    seq(2, '{4'b0001, 4'b0010});
    do_reset();
    seq(3, '{4'b0100, 4'b1000, 4'b0001});
    apply(1'b1, 1'b0, 0);
    // Five faults: dut_b's 2-bit error counter must saturate at 3.
    for (int i = 0; i < 5; i++) seq(2, '{4'b0001, 4'b0110});
    apply(1'b0, 1'b0, 0);

    cur = int'($urandom_range(0, 15));
    dsel = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        do_reset();
      end else if (r < 5) begin
        apply(1'b1, ($urandom_range(0, 1) == 1), cur);
      end else if ($urandom_range(0, 3) == 0) begin
        apply(1'b0, 1'b0, int'($urandom_range(0, 15)));
      end else begin
        if ($urandom_range(0, 39) == 0) dsel = ~dsel;
        if ($urandom_range(0, 11) == 0) cur = int'($urandom_range(0, 15));
        else cur = rot(cur, dsel);
        apply(1'b0, 1'b1, cur);
      end
    end
    apply(1'b0, 1'b0, 0);

    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clk);
    #3;
    check("drain_queue_a", qa.size(), 0);
    check("drain_queue_b", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
